// File: rtl/rx_spatial_cb.sv
// rx_spatial_cb: receive-side spatial channel-bonding merger.
//
// Collects one beat per lane from N_CHANNEL independent lane streams and
// reassembles the original wide AXI-Stream word. Each lane has its own FIFO
// so that skew between lanes is absorbed. A word occupies lanes
// N_CHANNEL-1 down to k. Full words use every lane (k = 0). The final word of
// a frame may stop early, at the lane k that carries tlast.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   s_axis_tdata   per-lane data, one unpacked entry per lane
//   s_axis_tkeep   per-lane byte keep
//   s_axis_tlast   per-lane last flag
//   s_axis_tvalid  per-lane valid
//   s_axis_tready  per-lane ready (lane FIFO not full, low while in reset)
//   m_axis_tdata   merged data, lane i in bits [(i+1)*DWIDTH_IN-1 -: DWIDTH_IN]
//   m_axis_tkeep   merged keep
//   m_axis_tlast   merged last
//   m_axis_tvalid  merged valid
//   m_axis_tready  downstream ready
//   lane_err       sticky flag: an assembled lane head had tkeep MSB = 0
module rx_spatial_cb #(
    parameter int unsigned DWIDTH_IN       = 240,
    parameter int unsigned DWIDTH_OUT      = 240,
    parameter int unsigned N_CHANNEL       = 1,
    parameter int unsigned LANE_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DWIDTH_IN-1:0]    s_axis_tdata  [N_CHANNEL],
    input  logic [DWIDTH_IN/8-1:0]  s_axis_tkeep  [N_CHANNEL],
    input  logic [N_CHANNEL-1:0]    s_axis_tlast,
    input  logic [N_CHANNEL-1:0]    s_axis_tvalid,
    output logic [N_CHANNEL-1:0]    s_axis_tready,
    output logic [DWIDTH_OUT-1:0]   m_axis_tdata,
    output logic [DWIDTH_OUT/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    lane_err
);

    localparam int unsigned KW = DWIDTH_IN / 8;
    localparam int unsigned EW = 1 + KW + DWIDTH_IN;
    localparam int unsigned AW = $clog2(LANE_FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(LANE_FIFO_DEPTH);

    // Lane FIFO head views and control
    logic [N_CHANNEL-1:0]                head_last;
    logic [N_CHANNEL-1:0][KW-1:0]        head_keep;
    logic [N_CHANNEL-1:0][DWIDTH_IN-1:0] head_data;
    logic [N_CHANNEL-1:0]                lane_empty;
    logic [N_CHANNEL-1:0]                pop_lane;

    // ------------------------------------------------------------------
    // Per-lane FIFOs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_CHANNEL; g++) begin : g_lane
        logic [EW-1:0] mem_q [LANE_FIFO_DEPTH];
        logic [AW-1:0] wr_ptr_q, wr_ptr_d;
        logic [AW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          push;
        logic          pop;
        logic [EW-1:0] head;

        // Ready depends only on the registered count, so a pop in the same
        // cycle never lets a push into a full FIFO.
        assign s_axis_tready[g] = rst_n & (cnt_q != FullCnt);

        assign push = s_axis_tvalid[g] & s_axis_tready[g];
        assign pop  = pop_lane[g];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            // Depth is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!push && pop) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage needs no reset: contents are only read when the count says
        // the entry is valid.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= {s_axis_tlast[g], s_axis_tkeep[g], s_axis_tdata[g]};
            end
        end

        assign head          = mem_q[rd_ptr_q];
        assign head_data[g]  = head[DWIDTH_IN-1:0];
        assign head_keep[g]  = head[DWIDTH_IN +: KW];
        assign head_last[g]  = head[EW-1];
        assign lane_empty[g] = (cnt_q == '0);
    end

    // ------------------------------------------------------------------
    // Word selection
    // ------------------------------------------------------------------
    // Walk down from the top lane over the non-empty run. The run ends either
    // at a head with tlast (that lane is k) or at lane 0 (k = 0). Hitting an
    // empty lane first means the word is not yet complete. Lanes below k are
    // never examined, so they cannot block completion.
    logic [N_CHANNEL-1:0] pop_mask;
    logic                 word_ok;
    logic                 word_last;
    logic                 scan_stop;

    always_comb begin
        pop_mask  = '0;
        word_ok   = 1'b0;
        word_last = 1'b0;
        scan_stop = 1'b0;
        for (int i = N_CHANNEL - 1; i >= 0; i--) begin
            if (!scan_stop) begin
                if (lane_empty[i]) begin
                    scan_stop = 1'b1;
                end else begin
                    pop_mask[i] = 1'b1;
                    if (head_last[i]) begin
                        word_ok   = 1'b1;
                        word_last = 1'b1;
                        scan_stop = 1'b1;
                    end else if (i == 0) begin
                        word_ok = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Assembly
    // ------------------------------------------------------------------
    logic [N_CHANNEL*DWIDTH_IN-1:0] merged_data;
    logic [N_CHANNEL*KW-1:0]        merged_keep;
    logic                           keep_msb_err;

    always_comb begin
        merged_data  = '0;
        merged_keep  = '0;
        keep_msb_err = 1'b0;
        for (int i = 0; i < N_CHANNEL; i++) begin
            if (pop_mask[i]) begin
                merged_data[i*DWIDTH_IN +: DWIDTH_IN] = head_data[i];
                merged_keep[i*KW +: KW]               = head_keep[i];
                if (!head_keep[i][KW-1]) begin
                    keep_msb_err = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic                    out_valid_q, out_valid_d;
    logic [DWIDTH_OUT-1:0]   out_data_q, out_data_d;
    logic [DWIDTH_OUT/8-1:0] out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    err_q, err_d;
    logic                    load;

    // Loading while the current word leaves keeps one word per cycle.
    assign load     = word_ok & (~out_valid_q | m_axis_tready);
    assign pop_lane = load ? pop_mask : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = merged_data;
            out_keep_d  = merged_keep;
            out_last_d  = word_last;
            // Malformed keep is flagged, but the word still goes out as-is.
            if (keep_msb_err) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign lane_err      = err_q;

endmodule

// File: tb/tb_rx_spatial_cb.sv
// Bench for rx_spatial_cb: a 4-lane x 64-bit instance and a 1-lane x 240-bit
// instance. Words are generated as whole bonded words; the expected merged
// word is built directly from the packing rule and queued, while each word's
// lane beats go onto per-lane driver queues.
module tb_rx_spatial_cb;
    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int DO  = 256;
    localparam int KO  = 32;
    localparam int DW1 = 240;
    localparam int KW1 = 30;
    localparam int W   = 289;

    typedef struct packed { logic last; logic [KW-1:0] keep; logic [DW-1:0] data; } beat_t;
    typedef struct packed { logic last; logic [KO-1:0] keep; logic [DO-1:0] data; } word_t;
    typedef struct packed { logic last; logic [KW1-1:0] keep; logic [DW1-1:0] data; } beat1_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-lane instance
    logic [DW-1:0] s_tdata [N];
    logic [KW-1:0] s_tkeep [N];
    logic [N-1:0]  s_tlast, s_tvalid, s_tready;
    logic [DO-1:0] m_tdata;
    logic [KO-1:0] m_tkeep;
    logic          m_tlast, m_tvalid, m_tready, lane_err;

    // 1-lane instance
    logic [DW1-1:0] s1_tdata [1];
    logic [KW1-1:0] s1_tkeep [1];
    logic [0:0]     s1_tlast, s1_tvalid, s1_tready;
    logic [DW1-1:0] m1_tdata;
    logic [KW1-1:0] m1_tkeep;
    logic           m1_tlast, m1_tvalid, m1_tready, lane_err1;

    rx_spatial_cb #(.DWIDTH_IN(DW), .DWIDTH_OUT(DO), .N_CHANNEL(N), .LANE_FIFO_DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .lane_err(lane_err)
    );

    rx_spatial_cb #(.DWIDTH_IN(DW1), .DWIDTH_OUT(DW1), .N_CHANNEL(1), .LANE_FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tlast(s1_tlast),
        .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tlast(m1_tlast),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready), .lane_err(lane_err1)
    );

    // Reference model state
    beat_t  lq [N][$];
    word_t  exp_q[$];
    word_t  got4[$];
    int     out_cyc4[$];
    beat1_t lq1[$];
    beat1_t exp1_q[$];
    int     out_cyc1[$];
    logic [DW-1:0] wd [N];
    logic [KW-1:0] wk [N];
    int     acc_cnt [N];
    int     n_out4 = 0;
    int     cyc = 0;
    int     n_pass = 0;
    int     n_total = 0;
    logic   hold4 = 1'b0;
    logic   hold1 = 1'b0;
    word_t  held4, cur4;
    beat1_t held1, cur1;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Queue one bonded word occupying lanes N-1..k from wd/wk.
    task automatic add_word(input int k, input logic last);
        word_t w;
        w = '0;
        for (int i = k; i < N; i++) begin
            lq[i].push_back({(i == k) ? last : 1'b0, wk[i], wd[i]});
            w.data[i*DW +: DW] = wd[i];
            w.keep[i*KW +: KW] = wk[i];
        end
        w.last = last;
        exp_q.push_back(w);
    endtask

    task automatic add_beat1(input logic [DW1-1:0] d, input logic last);
        beat1_t b;
        b = {last, {KW1{1'b1}}, d};
        lq1.push_back(b);
        exp1_q.push_back(b);
    endtask

    function automatic logic [DW1-1:0] rand240();
        logic [255:0] t;
        for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
        return t[DW1-1:0];
    endfunction

    function automatic logic [N-1:0] rand_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 3) != 0);
        return m;
    endfunction

    // Drive inputs just after the active edge, then wait for the falling edge.
    task automatic cycle_begin(input logic [N-1:0] en, input logic rdy, input logic rdy1);
        for (int i = 0; i < N; i++) begin
            if (en[i] && lq[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                {s_tlast[i], s_tkeep[i], s_tdata[i]} = lq[i][0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
                s_tkeep[i]  = '0;
                s_tdata[i]  = '0;
            end
        end
        if (lq1.size() > 0) begin
            s1_tvalid[0] = 1'b1;
            {s1_tlast[0], s1_tkeep[0], s1_tdata[0]} = lq1[0];
        end else begin
            s1_tvalid[0] = 1'b0;
            s1_tlast[0]  = 1'b0;
            s1_tkeep[0]  = '0;
            s1_tdata[0]  = '0;
        end
        m_tready  = rdy;
        m1_tready = rdy1;
        @(negedge clk);
    endtask

    // Account for handshakes that will happen at the next edge and check outputs.
    task automatic cycle_end();
        word_t e;
        beat1_t e1;
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i] === 1'b1) begin
                void'(lq[i].pop_front());
                acc_cnt[i]++;
            end
        end
        if (s1_tvalid[0] && s1_tready[0] === 1'b1) void'(lq1.pop_front());

        cur4 = {m_tlast, m_tkeep, m_tdata};
        if (hold4) begin
            check("hold4_valid", W'(m_tvalid), W'(1));
            check("hold4_word", W'(cur4), W'(held4));
        end
        if (m_tvalid === 1'b1 && m_tready) begin
            n_out4++;
            out_cyc4.push_back(cyc);
            got4.push_back(cur4);
            if (exp_q.size() == 0) check("spurious4", W'(m_tvalid), W'(0));
            else begin
                e = exp_q.pop_front();
                check("word4", W'(cur4), W'(e));
            end
        end
        hold4 = (m_tvalid === 1'b1) && !m_tready;
        held4 = cur4;

        cur1 = {m1_tlast, m1_tkeep, m1_tdata};
        if (hold1) check("hold1_word", W'(cur1), W'(held1));
        if (m1_tvalid === 1'b1 && m1_tready) begin
            out_cyc1.push_back(cyc);
            if (exp1_q.size() == 0) check("spurious1", W'(m1_tvalid), W'(0));
            else begin
                e1 = exp1_q.pop_front();
                check("beat1", W'(cur1), W'(e1));
            end
        end
        hold1 = (m1_tvalid === 1'b1) && !m1_tready;
        held1 = cur1;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle(input logic [N-1:0] en, input logic rdy, input logic rdy1);
        cycle_begin(en, rdy, rdy1);
        cycle_end();
    endtask

    task automatic drain(input int max_cyc, input bit rnd);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < max_cyc) begin
            if (rnd) cycle(rand_mask(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            else cycle('1, 1'b1, 1'b1);
            n++;
        end
        check("drain_left4", W'(exp_q.size()), W'(0));
        check("drain_left1", W'(exp1_q.size()), W'(0));
        repeat (3) cycle('1, 1'b1, 1'b1);
    endtask

    initial begin
        int c0;
        int nb;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;

        // Reset values
        rst_n = 1'b0;
        cycle('1, 1'b1, 1'b1);
        cycle_begin('1, 1'b1, 1'b1);
        check("rst_tready4", W'(s_tready), W'(0));
        check("rst_tready1", W'(s1_tready), W'(0));
        check("rst_out4", W'({m_tvalid, m_tlast, m_tkeep, m_tdata}), W'(0));
        check("rst_out1", W'({m1_tvalid, m1_tlast, m1_tkeep, m1_tdata}), W'(0));
        check("rst_err", W'({lane_err, lane_err1}), W'(0));
        cycle_end();
        rst_n = 1'b1;
        cycle_begin('1, 1'b1, 1'b1);
        check("rel_tready4", W'(s_tready), W'(4'hF));
        check("rel_tready1", W'(s1_tready), W'(1));
        cycle_end();

        // Aligned full words
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < N; i++) begin
                wd[i] = (64'(w) << 8) | 64'(i);
                wk[i] = 8'hFF;
            end
            add_word(0, 1'b0);
        end
        out_cyc4.delete();
        c0 = cyc;
        drain(40, 1'b0);
        check("aligned_count", W'(out_cyc4.size()), W'(8));
        check("aligned_first", W'(out_cyc4[0]), W'(c0 + 2));
        check("aligned_last", W'(out_cyc4[7]), W'(c0 + 9));

        // Partial last word on lanes 3,2, followed by a full word
        for (int i = 0; i < N; i++) begin
            wd[i] = {$urandom, $urandom};
            wk[i] = 8'hFF;
        end
        add_word(2, 1'b1);
        for (int i = 0; i < N; i++) wd[i] = {$urandom, $urandom};
        add_word(0, 1'b0);
        got4.delete();
        drain(40, 1'b0);
        check("partial_keep", W'(got4[0].keep), W'(32'hFFFF0000));
        check("partial_low", W'(got4[0].data[127:0]), W'(0));
        check("partial_last", W'(got4[0].last), W'(1));
        check("partial_next_keep", W'(got4[1].keep), W'(32'hFFFFFFFF));

        // Lane 0 skewed by 3 cycles
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < N; i++) begin
                wd[i] = {$urandom, $urandom};
                wk[i] = 8'hFF;
            end
            add_word(0, 1'b0);
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            cycle_begin((c < 3) ? 4'b1110 : 4'b1111, 1'b1, 1'b1);
            for (int l = 1; l < N; l++) begin
                if (s_tvalid[l]) check("skew_ready", W'(s_tready[l]), W'(1));
            end
            cycle_end();
        end
        drain(40, 1'b0);

        // Backpressure: 10 stalled cycles during continuous streaming
        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < N; i++) begin
                wd[i] = {$urandom, $urandom};
                wk[i] = 8'hFF;
            end
            add_word(0, 1'b0);
        end
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        repeat (9) cycle('1, 1'b0, 1'b1);
        cycle_begin('1, 1'b0, 1'b1);
        check("bp_tready", W'(s_tready), W'(0));
        check("bp_valid", W'(m_tvalid), W'(1));
        cycle_end();
        for (int i = 0; i < N; i++) check("bp_accepted", W'(acc_cnt[i]), W'(5));
        drain(60, 1'b0);

        // Randomized frames with random lane stalls and downstream ready
        for (int w = 0; w < 40; w++) begin
            int k;
            logic last;
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(1, 3);
                last = 1'b1;
            end else begin
                k = 0;
                last = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < N; i++) begin
                wd[i] = {$urandom, $urandom};
                wk[i] = {1'b1, 7'($urandom)};
            end
            add_word(k, last);
        end
        drain(2000, 1'b1);
        check("rand_err", W'(lane_err), W'(0));

        // Protocol error: lane 3 head with tkeep MSB clear
        for (int i = 0; i < N; i++) begin
            wd[i] = {$urandom, $urandom};
            wk[i] = (i == 3) ? 8'h7F : 8'hFF;
        end
        add_word(0, 1'b0);
        cycle('1, 1'b1, 1'b1);
        cycle_begin('1, 1'b1, 1'b1);
        check("err_before", W'(lane_err), W'(0));
        cycle_end();
        cycle_begin('1, 1'b1, 1'b1);
        check("err_set", W'({lane_err, m_tvalid}), W'(2'b11));
        cycle_end();
        drain(20, 1'b0);
        check("err_sticky", W'(lane_err), W'(1));

        // Mid-stream reset with data in the FIFOs and the output register
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < N; i++) begin
                wd[i] = {$urandom, $urandom};
                wk[i] = 8'hFF;
            end
            add_word(0, 1'b0);
        end
        repeat (4) cycle('1, 1'b0, 1'b1);
        rst_n = 1'b0;
        cycle_begin('1, 1'b0, 1'b1);
        check("mid_rst_tready", W'(s_tready), W'(0));
        cycle_end();
        for (int i = 0; i < N; i++) lq[i].delete();
        exp_q.delete();
        hold4 = 1'b0;
        rst_n = 1'b1;
        cycle_begin('1, 1'b1, 1'b1);
        check("mid_rst_out", W'({m_tvalid, m_tlast, m_tkeep, m_tdata}), W'(0));
        check("mid_rst_err", W'(lane_err), W'(0));
        check("mid_rst_ready", W'(s_tready), W'(4'hF));
        cycle_end();
        nb = n_out4;
        repeat (5) cycle('1, 1'b1, 1'b1);
        check("mid_rst_stale", W'(n_out4), W'(nb));
        for (int i = 0; i < N; i++) begin
            wd[i] = {$urandom, $urandom};
            wk[i] = 8'hFF;
        end
        add_word(1, 1'b1);
        drain(20, 1'b0);

        // Single lane: 5 beats, tlast on the fifth
        for (int b = 0; b < 5; b++) add_beat1(rand240(), b == 4);
        out_cyc1.delete();
        c0 = cyc;
        drain(40, 1'b0);
        check("n1_count", W'(out_cyc1.size()), W'(5));
        check("n1_first", W'(out_cyc1[0]), W'(c0 + 2));
        check("n1_last", W'(out_cyc1[4]), W'(c0 + 6));
        for (int b = 0; b < 12; b++) add_beat1(rand240(), $urandom_range(0, 3) == 0);
        drain(500, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
